// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between the instruction fetcher (I) and the load/store unit (D).
// Optional grant/stall performance counters are enabled with MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [31:0]       i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_ready_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic [31:0]       i_grant_cnt_o,
  output logic [31:0]       d_grant_cnt_o,
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t              state_q;
  logic                owner_q;
  logic                m_req_q;
  logic                m_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          starve_q, starve_d;
  logic                idle, i_win, d_win;

  assign idle = (state_q == IDLE);

  always_comb begin
    i_win    = i_req_i && (!d_req_i || (starve_q == LIM));
    d_win    = d_req_i && !i_win;
    starve_d = starve_q;
    if (idle) begin
      if (i_win || !i_req_i)
        starve_d = '0;
      else if (d_win && (starve_q != 4'hF))
        starve_d = starve_q + 4'd1;
    end
  end

  assign i_gnt_o = idle && i_win;
  assign d_gnt_o = idle && d_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      m_req_q  <= 1'b0;
      m_we_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          if (i_win || d_win) begin
            owner_q <= d_win;
            m_req_q <= 1'b1;
            m_we_q  <= d_win && d_we_i;
            addr_q  <= d_win ? d_addr_i : i_addr_i;
            wdata_q <= d_wdata_i;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (m_ready_i) begin
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (m_rvalid_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req_o    = m_req_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = addr_q;
  assign m_wdata_o  = wdata_q;
  assign i_rvalid_o = (state_q == RESP) && m_rvalid_i && !owner_q;
  assign d_rvalid_o = (state_q == RESP) && m_rvalid_i && owner_q;
  assign i_rdata_o  = m_rdata_i[31:0];
  assign d_rdata_o  = m_rdata_i;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] i_cnt_q, d_cnt_q, stall_q;

  // Each side that is requesting without being granted adds one stall cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      stall_q <= '0;
    end else begin
      i_cnt_q <= i_cnt_q + 32'(i_gnt_o);
      d_cnt_q <= d_cnt_q + 32'(d_gnt_o);
      stall_q <= stall_q + 32'(i_req_i && !i_gnt_o) + 32'(d_req_i && !d_gnt_o);
    end
  end

  assign i_grant_cnt_o = i_cnt_q;
  assign d_grant_cnt_o = d_cnt_q;
  assign stall_cnt_o   = stall_q;
`else
  assign i_grant_cnt_o = '0;
  assign d_grant_cnt_o = '0;
  assign stall_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus starvation and counter sequences.
// Counter expectations follow MEM_PORT_ARBITER_PERF_EN.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i;
  logic [63:0] d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [63:0] d_rdata_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o;
  logic [63:0] m_wdata_o;
  logic        m_ready_i, m_rvalid_i;
  logic [63:0] m_rdata_i;
  logic [31:0] i_grant_cnt_o, d_grant_cnt_o, stall_cnt_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_LIM(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_ready_i(m_ready_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .i_grant_cnt_o(i_grant_cnt_o), .d_grant_cnt_o(d_grant_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic        rst, ireq, dreq, dwe, mrdy, mrv;
    logic [31:0] iaddr, daddr;
    logic [63:0] wdata, rdata;
    logic [5:0]  ctl;   // {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we}
    logic [31:0] maddr;
    logic [63:0] mwdata;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] WD  = 64'h1122334455667788;
  localparam logic [63:0] RD1 = 64'hDEADBEEF_00000013;
  localparam logic [63:0] RD2 = 64'h00000000_00000055;
  localparam logic [63:0] RD3 = 64'hCAFEF00D_12345678;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic ireq, input logic [31:0] iaddr,
                     input logic dreq, input logic dwe, input logic [31:0] daddr,
                     input logic [63:0] wdata, input logic mrdy, input logic mrv,
                     input logic [63:0] rdata, input logic [5:0] ctl,
                     input logic [31:0] maddr, input logic [63:0] mwdata);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.wdata = wdata; v.mrdy = mrdy; v.mrv = mrv; v.rdata = rdata;
    v.ctl = ctl; v.maddr = maddr; v.mwdata = mwdata;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    i_req_i = 0; i_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0;
    m_ready_i = 0; m_rvalid_i = 0; m_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1; idle_inputs(); rst_i = 1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1; rst_i = 0;
  endtask

  // One transaction on a single side; memory responds immediately.
  task automatic xfer(input bit is_d, input string name);
    bit got;
    @(posedge clk_i); #1;
    m_ready_i = 1; m_rvalid_i = 1;
    if (is_d) begin d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100; end
    else begin i_req_i = 1; i_addr_i = 32'h200; end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (is_d ? d_gnt_o : i_gnt_o) got = 1;
      else begin @(posedge clk_i); #1; end
    end
    chk({name, "_gnt"}, 64'(got), 64'd1);
    @(posedge clk_i); #1; i_req_i = 0; d_req_i = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (is_d ? d_rvalid_o : i_rvalid_o) got = 1;
      else begin @(posedge clk_i); #1; end
    end
    chk({name, "_rvalid"}, 64'(got), 64'd1);
  endtask

  initial begin
    bit   exp_d [8];
    int   gcyc  [8];
    bit   gside [8];
    int   n;
    bit   got;

    rst_i = 1; idle_inputs();
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;

    //  rst ireq iaddr dreq dwe daddr wdata mrdy mrv rdata ctl maddr mwdata
    add(1, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000000, 0,     0);
    add(0, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000000, 0,     0);
    add(0, 1, 'h10,  0, 0, 0,     0,  1, 0, RD1, 6'b100000, 0,     0);
    add(0, 0, 0,     0, 0, 0,     0,  1, 0, RD1, 6'b000010, 'h10,  0);
    add(0, 0, 0,     0, 0, 0,     0,  1, 1, RD1, 6'b001000, 'h10,  0);
    add(0, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000000, 'h10,  0);
    add(0, 0, 0,     1, 1, 'h40,  WD, 0, 0, 0,   6'b010000, 'h10,  0);
    add(0, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000011, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000011, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000011, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  1, 0, 0,   6'b000011, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  1, 0, 0,   6'b000000, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  0, 1, 0,   6'b000100, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000000, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  0, 1, 0,   6'b000000, 'h40,  WD);
    add(0, 1, 'h20,  0, 0, 0,     0,  0, 0, 0,   6'b100000, 'h40,  WD);
    add(0, 0, 0,     0, 0, 0,     0,  0, 1, 0,   6'b000010, 'h20,  0);
    add(0, 0, 0,     0, 0, 0,     0,  1, 0, 0,   6'b000010, 'h20,  0);
    add(0, 0, 0,     0, 0, 0,     0,  0, 1, RD2, 6'b001000, 'h20,  0);
    add(0, 0, 0,     1, 0, 'h80,  0,  0, 0, 0,   6'b010000, 'h20,  0);
    add(0, 0, 0,     0, 0, 0,     0,  1, 0, 0,   6'b000010, 'h80,  0);
    add(0, 0, 0,     0, 0, 0,     0,  0, 1, RD3, 6'b000100, 'h80,  0);
    add(0, 1, 'h30,  0, 0, 0,     0,  0, 0, 0,   6'b100000, 'h80,  0);
    add(0, 0, 0,     0, 0, 0,     0,  1, 0, 0,   6'b000010, 'h30,  0);
    add(1, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000000, 'h30,  0);
    add(0, 0, 0,     0, 0, 0,     0,  0, 1, RD1, 6'b000000, 0,     0);
    add(0, 0, 0,     0, 0, 0,     0,  0, 0, 0,   6'b000000, 0,     0);

    foreach (vq[i]) begin
      rst_i = vq[i].rst; i_req_i = vq[i].ireq; i_addr_i = vq[i].iaddr;
      d_req_i = vq[i].dreq; d_we_i = vq[i].dwe; d_addr_i = vq[i].daddr;
      d_wdata_i = vq[i].wdata; m_ready_i = vq[i].mrdy; m_rvalid_i = vq[i].mrv;
      m_rdata_i = vq[i].rdata;
      @(negedge clk_i);
      chk($sformatf("vec%0d_ctl", i),
          64'({i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, m_req_o, m_we_o}), 64'(vq[i].ctl));
      chk($sformatf("vec%0d_maddr", i), 64'(m_addr_o), 64'(vq[i].maddr));
      chk($sformatf("vec%0d_mwdata", i), m_wdata_o, vq[i].mwdata);
      if (vq[i].ctl[3]) chk($sformatf("vec%0d_irdata", i), 64'(i_rdata_o), 64'(vq[i].rdata[31:0]));
      if (vq[i].ctl[2]) chk($sformatf("vec%0d_drdata", i), d_rdata_o, vq[i].rdata);
      @(posedge clk_i); #1;
    end

    // Both sides requesting continuously: expect D,D,D,I repeating, one grant every 3 cycles.
    do_reset();
    exp_d = '{1, 1, 1, 0, 1, 1, 1, 0};
    i_req_i = 1; i_addr_i = 32'h300; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400;
    m_ready_i = 1; m_rvalid_i = 1;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk_i);
      if (i_gnt_o && d_gnt_o) chk("both_gnt", 64'd1, 64'd0);
      if (i_rvalid_o && d_rvalid_o) chk("both_rvalid", 64'd1, 64'd0);
      if (i_gnt_o || d_gnt_o) begin
        gside[n] = d_gnt_o; gcyc[n] = c; n++;
      end
      @(posedge clk_i); #1;
    end
    chk("starve_grant_count", 64'(n), 64'd8);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("starve_order%0d", k), 64'(gside[k]), 64'(exp_d[k]));
      if (k > 0) chk($sformatf("starve_gap%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd3);
    end
    idle_inputs();

    // Counters: 4 solo I, one contended pair (D then I, I stalls 3 cycles), 1 solo D.
    do_reset();
    for (int k = 0; k < 4; k++) xfer(1'b0, $sformatf("perf_i%0d", k));
    @(posedge clk_i); #1;
    i_req_i = 1; i_addr_i = 32'h500; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h600;
    @(negedge clk_i);
    chk("pair_first", 64'({i_gnt_o, d_gnt_o}), 64'b01);
    @(posedge clk_i); #1; d_req_i = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (i_gnt_o) got = 1;
      else begin @(posedge clk_i); #1; end
    end
    chk("pair_i_gnt", 64'(got), 64'd1);
    @(posedge clk_i); #1; i_req_i = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk_i);
      if (i_rvalid_o) got = 1;
      else begin @(posedge clk_i); #1; end
    end
    chk("pair_i_rvalid", 64'(got), 64'd1);
    xfer(1'b1, "perf_d");
    @(posedge clk_i); #1; idle_inputs();
    @(negedge clk_i);
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("i_grant_cnt", 64'(i_grant_cnt_o), 64'd5);
    chk("d_grant_cnt", 64'(d_grant_cnt_o), 64'd2);
    chk("stall_cnt",   64'(stall_cnt_o),   64'd3);
`else
    chk("i_grant_cnt", 64'(i_grant_cnt_o), 64'd0);
    chk("d_grant_cnt", 64'(d_grant_cnt_o), 64'd0);
    chk("stall_cnt",   64'(stall_cnt_o),   64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
